// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: fetch fault codes, fetch FSM states, canonical NOP.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_RANGE      = 2'd2
  } fetch_fault_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns PC, drives word address to comb imem, registers the instruction for decode.
// One cycle pc->if_*; holds pc and output while decode stalls (if_valid && !id_ready).
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int                  WIDTH1   = 32,
  parameter logic [WIDTH1-1:0]   RESET_PC = '0,
  parameter int                  MEM_SIZE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [WIDTH1-1:0] redirect_pc,
  input  logic              id_ready,
  output logic [WIDTH1-1:0] imem_addr,
  input  logic [WIDTH1-1:0] imem_rdata,
  output logic              if_valid,
  output logic [WIDTH1-1:0] if_pc,
  output logic [WIDTH1-1:0] if_instr,
  output logic [1:0]        if_fault,
  output logic [WIDTH1-1:0] fetch_count
);

  localparam logic [WIDTH1-1:0] MEM_WORDS = WIDTH1'(MEM_SIZE);

  fetch_state_t      state_q, state_d;
  fetch_fault_t      if_fault_q, if_fault_d, fetch_fault;
  logic [WIDTH1-1:0] pc_q, pc_d;
  logic [WIDTH1-1:0] if_pc_q, if_pc_d;
  logic [WIDTH1-1:0] if_instr_q, if_instr_d;
  logic [WIDTH1-1:0] fetch_count_q, fetch_count_d;
  logic              if_valid_q, if_valid_d;
  logic              run, handshake, adv;

  assign imem_addr = {2'b00, pc_q[WIDTH1-1:2]};

  // Misaligned wins over out-of-range when both apply.
  always_comb begin
    fetch_fault = FAULT_NONE;
    if (pc_q[1:0] != 2'b00)       fetch_fault = FAULT_MISALIGNED;
    else if (imem_addr >= MEM_WORDS) fetch_fault = FAULT_RANGE;
  end

  assign handshake = if_valid_q && id_ready;
  assign adv       = run && (!if_valid_q || id_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)                       state_d = RUN;
    else if (state_q == BOOT)                 state_d = RUN;
    else if (adv && fetch_fault != FAULT_NONE) state_d = FAULT;
  end

  always_comb begin
    run = (state_q == RUN);
  end

  always_comb begin
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_fault_d    = if_fault_q;
    fetch_count_d = fetch_count_q;

    // A handshake is decode's consumption; it counts even when a redirect squashes the register.
    if (handshake && if_fault_q == FAULT_NONE) fetch_count_d = fetch_count_q + WIDTH1'(1);

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
    end else if (adv) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_fault_d = fetch_fault;
      if (fetch_fault == FAULT_NONE) begin
        if_instr_d = imem_rdata;
        pc_d       = pc_q + WIDTH1'(4);
      end else begin
        if_instr_d = WIDTH1'(NOP_INSTR);
      end
    end else if (handshake) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= WIDTH1'(NOP_INSTR);
      if_fault_q    <= FAULT_NONE;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_fault_q    <= if_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_fault    = if_fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: transaction-level model checked every cycle plus directed literal checks.
module tb_instruction_fetch;

  localparam int MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  if_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.WIDTH1(32), .RESET_PC(32'h0), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_fault(if_fault), .fetch_count(fetch_count)
  );

  // Word i of memory holds addi x((i+1)%32), x0, i+1.
  function automatic logic [31:0] addi_word(input logic [31:0] idx);
    logic [31:0] n;
    n = idx + 32'd1;
    return (n << 20) | ((n & 32'd31) << 7) | 32'h13;
  endfunction

  assign imem_rdata = (imem_addr < MEM_SIZE) ? addi_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pc, "waiting for first fetch" and "stopped after a fault" flags, output slot, count.
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_boot, m_halt, m_vld;
  int          m_fault;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_boot = 1'b1; m_halt = 1'b0; m_vld = 1'b0;
      m_ipc = 32'h0; m_instr = 32'h13; m_fault = 0; m_cnt = 32'h0;
    end else begin
      if (m_vld && id_ready && m_fault == 0) m_cnt = m_cnt + 1;
      if (redirect_valid) begin
        m_pc = redirect_pc; m_vld = 1'b0; m_boot = 1'b0; m_halt = 1'b0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_halt && (!m_vld || id_ready)) begin
        m_vld = 1'b1;
        m_ipc = m_pc;
        if (m_pc % 4 != 0)             m_fault = 1;
        else if (m_pc / 4 >= MEM_SIZE) m_fault = 2;
        else                           m_fault = 0;
        if (m_fault != 0) begin
          m_instr = 32'h13;
          m_halt  = 1'b1;
        end else begin
          m_instr = addi_word(m_pc / 4);
          m_pc    = m_pc + 4;
        end
      end else if (m_vld && id_ready) begin
        m_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", {31'b0, if_valid}, {31'b0, m_vld});
      chk("m_addr", imem_addr, m_pc >> 2);
      chk("m_count", fetch_count, m_cnt);
      if (m_vld) begin
        chk("m_pc", if_pc, m_ipc);
        chk("m_instr", if_instr, m_instr);
        chk("m_fault", {30'b0, if_fault}, m_fault[31:0]);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_fault", {30'b0, if_fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // Boot cycle, then three back-to-back fetches.
    @(negedge clk); chk("boot_idle", {31'b0, if_valid}, 32'd0);
    @(negedge clk); chk("i0", if_instr, 32'h0010_0093); chk("i0_pc", if_pc, 32'h0);
    @(negedge clk); chk("i1", if_instr, 32'h0020_0113); chk("i1_pc", if_pc, 32'h4);
    @(negedge clk); chk("i2", if_instr, 32'h0030_0193); chk("i2_pc", if_pc, 32'h8);
    chk("cnt2", fetch_count, 32'd2);

    // Stall for three cycles.
    id_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_instr", if_instr, 32'h0030_0193);
      chk("stall_cnt", fetch_count, 32'd2);
    end
    id_ready = 1'b1;
    @(negedge clk); chk("rel_pc", if_pc, 32'hC); chk("cnt3", fetch_count, 32'd3);

    // Redirect while stalled squashes without counting.
    id_ready = 1'b0;
    redirect_to(32'h40);
    chk("squash", {31'b0, if_valid}, 32'd0); chk("squash_cnt", fetch_count, 32'd3);
    id_ready = 1'b1;
    @(negedge clk); chk("r40_pc", if_pc, 32'h40); chk("r40_instr", if_instr, 32'h0110_0893);

    // Misaligned target: one NOP fault output, then nothing until redirect.
    redirect_to(32'h42);
    chk("hs_redir_cnt", fetch_count, 32'd4);
    @(negedge clk);
    chk("mis_fault", {30'b0, if_fault}, 32'd1); chk("mis_instr", if_instr, 32'h13);
    chk("mis_pc", if_pc, 32'h42);
    @(negedge clk); chk("mis_drain", {31'b0, if_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("mis_stop", {31'b0, if_valid}, 32'd0); chk("mis_cnt", fetch_count, 32'd4);
    redirect_to(32'h0);
    @(negedge clk); chk("recov_instr", if_instr, 32'h0010_0093);

    // Out-of-range target.
    redirect_to(32'h1000);
    chk("cnt5", fetch_count, 32'd5);
    @(negedge clk); chk("rng_fault", {30'b0, if_fault}, 32'd2); chk("rng_pc", if_pc, 32'h1000);
    @(negedge clk); chk("rng_cnt", fetch_count, 32'd5);

    // Redirect coincident with a good handshake counts once and clears.
    redirect_to(32'h0);
    @(negedge clk); chk("v_pc0", {31'b0, if_valid}, 32'd1);
    redirect_to(32'h80);
    chk("hs_cnt6", fetch_count, 32'd6); chk("hs_clear", {31'b0, if_valid}, 32'd0);
    @(negedge clk); chk("r80_instr", if_instr, 32'h0210_0093);
    repeat (5) @(negedge clk);
    chk("thru_pc", if_pc, 32'h94); chk("thru_cnt", fetch_count, 32'd11);

    // Mixed stalls and redirects, including the top of memory.
    for (int i = 0; i < 40; i++) begin
      id_ready       = (i % 4 != 3);
      redirect_valid = (i == 10 || i == 25);
      redirect_pc    = (i == 10) ? 32'hFF8 : 32'h200;
      @(negedge clk);
    end
    redirect_valid = 1'b0; id_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", {31'b0, if_valid}, 32'd1);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk("reboot_idle", {31'b0, if_valid}, 32'd0);
    @(negedge clk); chk("reboot_instr", if_instr, 32'h0010_0093); chk("reboot_cnt", fetch_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
